ysyx_23060025_mdu: RTL
======================

Name: ysyx_23060025_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit; next-generation companion to the single-cycle integer ALU in the EXU.
- Implements the full RV32M op set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for any even DATA_LEN.
- Iterative radix-2 datapath behind a valid/ready handshake on both sides.
- EXU stalls while in_ready is low; the flush input supports pipeline redirects.

Parameters:
- DATA_LEN, 32, operand/result width; even, at least 8.
- CNT_W, $clog2(DATA_LEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  RISC-V funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1  in  DATA_LEN  rs1 operand.
- src2  in  DATA_LEN  rs2 operand.
- flush  in  1  abort current operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_LEN  result value.

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, result=0, counter=0. Reset mid-CALC or mid-DONE discards all work; no out_valid is produced.
- Handshake:
  - Request accepted on the cycle T where in_valid && in_ready.
  - op, src1 and src2 are latched at T and need not be held afterwards.
  - Result transfers when out_valid && out_ready.
  - result and out_valid stay stable until the transfer completes.
- FSM states and transitions:
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept of a special-case divide.
  - CALC -> DONE when the counter reaches DATA_LEN.
  - DONE -> IDLE on output transfer.
  - in_ready is high only in IDLE. There is no same-cycle DONE->accept; the next accept is the cycle after the transfer.
- Multiply datapath:
  - Operands are sign- or zero-extended per op to DATA_LEN+1 bits (MULHSU: src1 signed, src2 unsigned).
  - Shift-add runs 1 bit/cycle over DATA_LEN cycles with a 2*DATA_LEN+2-bit accumulator; sign correction is applied on the final step.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide datapath:
  - Restoring division on magnitudes, 1 quotient bit/cycle, DATA_LEN cycles.
  - Signed ops negate the quotient when the operand signs differ; the remainder takes the sign of src1.
- Latency: normal ops raise out_valid at T+DATA_LEN+1 (T+33 for DATA_LEN=32).
- Special cases, decided at accept and going straight to DONE with out_valid at T+1:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return src1.
  - Signed overflow (src1 = MIN, src2 = -1): DIV returns MIN; REM returns 0.
- Flush: from any state, next cycle is IDLE, out_valid=0, in_ready=1. A pending DONE result is dropped.
- Simultaneous events:
  - flush together with in_valid in IDLE: the request is not accepted.
  - rst dominates flush.
- Arithmetic wraps modulo 2^DATA_LEN; no exceptions or flags.

Optional Feature:
- Macro: YSYX_23060025_MDU_FAST_MUL_EN.
- Defined:
  - All multiply ops use one combinational signed (DATA_LEN+1)x(DATA_LEN+1) multiply.
  - Result is registered; accept goes IDLE -> DONE, out_valid at T+1.
  - The divider path is unchanged and the shift-add multiply logic is omitted.
- Undefined: iterative multiply as above, latency DATA_LEN+1.

Decomposition:
- Shared define file / package:
  - MDU_OP_* constants (3-bit funct3 codes).
  - FSM state encodings MDU_IDLE/MDU_CALC/MDU_DONE.
  - Helper for op class decode (is_div, is_signed_src1, is_signed_src2, want_high/want_rem).
- One sub-module: ysyx_23060025_mdu_div_core.
  - Holds the magnitude restoring-divide iteration register (remainder/quotient shift pair plus step enable).
  - Instantiated by the top, which owns the FSM, sign handling, special cases, multiply path and output register.

Test Plan (DATA_LEN=32 unless noted):
- MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB, out_valid exactly 33 cycles after accept. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. All four with out_valid at T+1.
- Backpressure: out_ready held low 5 cycles after out_valid -> result stable, in_ready=0; transfer on out_ready=1, in_ready=1 the next cycle. Back-to-back requests then complete in order.
- Flush at T+10 of a DIV -> out_valid never rises, in_ready=1 at T+11. rst at T+10 -> all outputs at reset values at T+11. Repeat with DATA_LEN=16: MULHU 0xFFFF x 0xFFFF -> 0xFFFE at T+17.
- With YSYX_23060025_MDU_FAST_MUL_EN defined: MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB at T+1; DIV latency still 33.

Source files
------------

// File: rtl/ysyx_23060025_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_mdu_pkg
// Description : Shared definitions for the multi-cycle multiply/divide unit:
//               funct3 op codes, FSM state encodings and an op-class decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060025_mdu_pkg;

    // RISC-V funct3 codes of the M extension
    localparam logic [2:0] MDU_OP_MUL    = 3'd0;
    localparam logic [2:0] MDU_OP_MULH   = 3'd1;
    localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
    localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
    localparam logic [2:0] MDU_OP_DIV    = 3'd4;
    localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
    localparam logic [2:0] MDU_OP_REM    = 3'd6;
    localparam logic [2:0] MDU_OP_REMU   = 3'd7;

    // FSM state encodings
    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_CALC = 2'd1;
    localparam logic [1:0] MDU_DONE = 2'd2;

    typedef struct packed {
        logic is_div;
        logic is_signed_src1;
        logic is_signed_src2;
        logic want_high_rem;   // multiply: high half; divide: remainder
    } mdu_cls_t;

    function automatic mdu_cls_t mdu_decode(input logic [2:0] op);
        mdu_cls_t c;
        c.is_div = op[2];
        if (op[2]) begin
            // DIV/REM signed, DIVU/REMU unsigned
            c.is_signed_src1 = ~op[0];
            c.is_signed_src2 = ~op[0];
            c.want_high_rem  = op[1];
        end else begin
            // MUL low half is extension-agnostic; treat it as signed x signed
            c.is_signed_src1 = (op != MDU_OP_MULHU);
            c.is_signed_src2 = ~op[1];
            c.want_high_rem  = (op != MDU_OP_MUL);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060025_mdu_div_core.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_mdu_div_core
// Description : Magnitude restoring divider, one quotient bit per step.
//               Ports: clk, rst; i_load (capture dividend/divisor, clear
//               remainder); i_step (perform one iteration); o_quo_nxt and
//               o_rem_nxt present the values the current step will produce,
//               so the caller can capture the final result on the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_mdu_div_core
    import ysyx_23060025_mdu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [DATA_LEN-1:0] i_dividend,
    input  logic [DATA_LEN-1:0] i_divisor,
    output logic [DATA_LEN-1:0] o_quo_nxt,
    output logic [DATA_LEN-1:0] o_rem_nxt
);

    logic [DATA_LEN-1:0] r_rem_q, w_rem_d;
    logic [DATA_LEN-1:0] r_quo_q, w_quo_d;
    logic [DATA_LEN-1:0] r_dvs_q, w_dvs_d;
    logic [DATA_LEN:0]   w_shift;
    logic [DATA_LEN:0]   w_diff;
    logic                w_ge;

    // Partial remainder shifted left with the next dividend bit; it never
    // exceeds 2*divisor-1, so the borrow bit of the subtraction is exactly
    // "shifted < divisor".
    assign w_shift   = {r_rem_q, r_quo_q[DATA_LEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs_q};
    assign w_ge      = ~w_diff[DATA_LEN];
    assign o_rem_nxt = w_ge ? w_diff[DATA_LEN-1:0] : w_shift[DATA_LEN-1:0];
    assign o_quo_nxt = {r_quo_q[DATA_LEN-2:0], w_ge};

    always_comb begin
        w_rem_d = r_rem_q;
        w_quo_d = r_quo_q;
        w_dvs_d = r_dvs_q;
        if (i_load) begin
            w_rem_d = '0;
            w_quo_d = i_dividend;
            w_dvs_d = i_divisor;
        end else if (i_step) begin
            w_rem_d = o_rem_nxt;
            w_quo_d = o_quo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem_q <= '0;
            r_quo_q <= '0;
            r_dvs_q <= '0;
        end else begin
            r_rem_q <= w_rem_d;
            r_quo_q <= w_quo_d;
            r_dvs_q <= w_dvs_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060025_mdu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_mdu
// Description : Multi-cycle RV32M multiply/divide unit with valid/ready
//               handshakes. Owns the FSM, sign handling, divide special
//               cases, the multiply path and the output register.
//               Ports: clk, rst (sync, active high); in_valid/in_ready, op,
//               src1, src2 (request); flush (abort); out_valid/out_ready,
//               result (response).
//               Optional macro YSYX_23060025_MDU_FAST_MUL_EN: single-cycle
//               combinational multiply instead of the iterative shift-add.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_mdu
    import ysyx_23060025_mdu_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int CNT_W    = $clog2(DATA_LEN) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic [DATA_LEN-1:0] src1,
    input  logic [DATA_LEN-1:0] src2,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] result
);

    localparam int                  W      = 2*DATA_LEN + 2;
    localparam logic [DATA_LEN-1:0] C_MIN  = {1'b1, {(DATA_LEN-1){1'b0}}};
    localparam logic [CNT_W-1:0]    C_LAST = CNT_W'(DATA_LEN-1);

    logic [1:0]          r_state_q, w_state_d;
    logic [CNT_W-1:0]    r_cnt_q, w_cnt_d;
    logic                r_is_div_q, w_is_div_d;
    logic                r_want_q, w_want_d;
    logic                r_neg_quo_q, w_neg_quo_d;
    logic                r_neg_rem_q, w_neg_rem_d;
    logic [DATA_LEN-1:0] r_result_q, w_result_d;

    mdu_cls_t            w_cls;
    logic                w_accept;
    logic                w_last;
    logic [DATA_LEN:0]   w_a_ext, w_b_ext;
    logic                w_s1_neg, w_s2_neg;
    logic [DATA_LEN-1:0] w_mag1, w_mag2;
    logic                w_div_load, w_div_step;
    logic [DATA_LEN-1:0] w_quo_nxt, w_rem_nxt, w_div_res;

    assign w_cls     = mdu_decode(op);
    assign in_ready  = (r_state_q == MDU_IDLE);
    assign out_valid = (r_state_q == MDU_DONE);
    assign result    = r_result_q;
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_last    = (r_cnt_q == C_LAST);

    assign w_a_ext  = {w_cls.is_signed_src1 & src1[DATA_LEN-1], src1};
    assign w_b_ext  = {w_cls.is_signed_src2 & src2[DATA_LEN-1], src2};

    // Divide works on magnitudes; -MIN wraps to MIN, which is the correct
    // unsigned magnitude 2^(DATA_LEN-1).
    assign w_s1_neg = w_cls.is_signed_src1 & src1[DATA_LEN-1];
    assign w_s2_neg = w_cls.is_signed_src2 & src2[DATA_LEN-1];
    assign w_mag1   = w_s1_neg ? -src1 : src1;
    assign w_mag2   = w_s2_neg ? -src2 : src2;

    ysyx_23060025_mdu_div_core #(
        .DATA_LEN (DATA_LEN)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_div_load),
        .i_step     (w_div_step),
        .i_dividend (w_mag1),
        .i_divisor  (w_mag2),
        .o_quo_nxt  (w_quo_nxt),
        .o_rem_nxt  (w_rem_nxt)
    );

    assign w_div_res = r_want_q ? (r_neg_rem_q ? -w_rem_nxt : w_rem_nxt)
                                : (r_neg_quo_q ? -w_quo_nxt : w_quo_nxt);

`ifdef YSYX_23060025_MDU_FAST_MUL_EN
    // Both operands sign-extended to the full product width; the modular
    // W-bit product equals the signed (DATA_LEN+1)x(DATA_LEN+1) product.
    logic [W-1:0]        w_prod;
    logic [DATA_LEN-1:0] w_fast_res;
    assign w_prod     = {{(DATA_LEN+1){w_a_ext[DATA_LEN]}}, w_a_ext}
                      * {{(DATA_LEN+1){w_b_ext[DATA_LEN]}}, w_b_ext};
    assign w_fast_res = w_cls.want_high_rem ? w_prod[2*DATA_LEN-1:DATA_LEN]
                                            : w_prod[DATA_LEN-1:0];
`else
    // Shift-add over the low DATA_LEN multiplier bits. The multiplier's
    // extension bit carries weight -2^DATA_LEN, so on the last step the
    // multiplicand (then a<<(DATA_LEN-1)) is subtracted once more, doubled.
    logic [W-1:0]        r_acc_q, w_acc_d, r_mcand_q, w_mcand_d, w_acc_nxt;
    logic [DATA_LEN-1:0] r_mplier_q, w_mplier_d, w_mul_res;
    logic                r_bsign_q, w_bsign_d;
    assign w_acc_nxt = r_acc_q + (r_mplier_q[0] ? r_mcand_q : '0)
                     - ((w_last && r_bsign_q) ? (r_mcand_q << 1) : '0);
    assign w_mul_res = r_want_q ? w_acc_nxt[2*DATA_LEN-1:DATA_LEN]
                                : w_acc_nxt[DATA_LEN-1:0];
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_is_div_d  = r_is_div_q;
        w_want_d    = r_want_q;
        w_neg_quo_d = r_neg_quo_q;
        w_neg_rem_d = r_neg_rem_q;
        w_result_d  = r_result_q;
        w_div_load  = 1'b0;
        w_div_step  = 1'b0;
`ifndef YSYX_23060025_MDU_FAST_MUL_EN
        w_acc_d     = r_acc_q;
        w_mcand_d   = r_mcand_q;
        w_mplier_d  = r_mplier_q;
        w_bsign_d   = r_bsign_q;
`endif
        case (r_state_q)
            MDU_IDLE: begin
                if (w_accept) begin
                    w_cnt_d    = '0;
                    w_is_div_d = w_cls.is_div;
                    w_want_d   = w_cls.want_high_rem;
                    if (w_cls.is_div) begin
                        if (src2 == '0) begin
                            w_result_d = w_cls.want_high_rem ? src1 : '1;
                            w_state_d  = MDU_DONE;
                        end else if (w_cls.is_signed_src1 && src1 == C_MIN && src2 == '1) begin
                            w_result_d = w_cls.want_high_rem ? '0 : C_MIN;
                            w_state_d  = MDU_DONE;
                        end else begin
                            w_div_load  = 1'b1;
                            w_neg_quo_d = w_s1_neg ^ w_s2_neg;
                            w_neg_rem_d = w_s1_neg;
                            w_state_d   = MDU_CALC;
                        end
                    end else begin
`ifdef YSYX_23060025_MDU_FAST_MUL_EN
                        w_result_d = w_fast_res;
                        w_state_d  = MDU_DONE;
`else
                        w_acc_d    = '0;
                        w_mcand_d  = {{(DATA_LEN+1){w_a_ext[DATA_LEN]}}, w_a_ext};
                        w_mplier_d = w_b_ext[DATA_LEN-1:0];
                        w_bsign_d  = w_b_ext[DATA_LEN];
                        w_state_d  = MDU_CALC;
`endif
                    end
                end
            end
            MDU_CALC: begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
                if (r_is_div_q) begin
                    w_div_step = 1'b1;
                end
`ifndef YSYX_23060025_MDU_FAST_MUL_EN
                else begin
                    w_acc_d    = w_acc_nxt;
                    w_mcand_d  = r_mcand_q << 1;
                    w_mplier_d = r_mplier_q >> 1;
                end
`endif
                if (w_last) begin
                    w_state_d = MDU_DONE;
`ifdef YSYX_23060025_MDU_FAST_MUL_EN
                    w_result_d = r_is_div_q ? w_div_res : '0;
`else
                    w_result_d = r_is_div_q ? w_div_res : w_mul_res;
`endif
                end
            end
            MDU_DONE: begin
                if (out_ready) begin
                    w_state_d = MDU_IDLE;
                end
            end
            default: w_state_d = MDU_IDLE;
        endcase
        if (flush) begin
            w_state_d = MDU_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= MDU_IDLE;
            r_cnt_q     <= '0;
            r_is_div_q  <= 1'b0;
            r_want_q    <= 1'b0;
            r_neg_quo_q <= 1'b0;
            r_neg_rem_q <= 1'b0;
            r_result_q  <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_is_div_q  <= w_is_div_d;
            r_want_q    <= w_want_d;
            r_neg_quo_q <= w_neg_quo_d;
            r_neg_rem_q <= w_neg_rem_d;
            r_result_q  <= w_result_d;
        end
    end

`ifndef YSYX_23060025_MDU_FAST_MUL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q    <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_bsign_q  <= 1'b0;
        end else begin
            r_acc_q    <= w_acc_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_bsign_q  <= w_bsign_d;
        end
    end
`endif

endmodule
`default_nettype wire
